// File: rtl/byte_pair_arbiter.sv
// Round-robin arbiter between two byte requesters sharing one byte-pair packer.
// A grant is held until both bytes of a word are taken; the word then waits in a one-entry output register.
module byte_pair_arbiter #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [DW-1:0]   req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [DW-1:0]   req1_data,
  output logic            req1_ready,
  input  logic            flush,
  output logic            out_valid,
  output logic [2*DW-1:0] out_data,
  output logic            out_src,
  input  logic            out_ready,
  output logic            busy,
  output logic [7:0]      out_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_gnt;
  logic            w_gnt_nxt;
  logic            r_last_grant;
  logic            w_last_grant_nxt;
  logic            r_out_valid;
  logic [2*DW-1:0] r_out_data;
  logic            r_out_src;
  logic [7:0]      r_out_cnt;

  logic            w_sel_valid;
  logic [DW-1:0]   w_sel_data;
  logic            w_take_byte0;
  logic            w_take_byte1;
  logic            w_out_hs;
  logic            w_ready0;
  logic            w_ready1;

  assign w_sel_valid = r_gnt ? req1_valid : req0_valid;
  assign w_sel_data  = r_gnt ? req1_data  : req0_data;

  // Control state, current grant and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Next-state, grant decision and ready generation (ready never depends on valid)
  always_comb begin
    w_state_nxt      = r_state;
    w_gnt_nxt        = r_gnt;
    w_last_grant_nxt = r_last_grant;
    w_take_byte0     = 1'b0;
    w_take_byte1     = 1'b0;
    w_out_hs         = 1'b0;
    w_ready0         = 1'b0;
    w_ready1         = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          w_gnt_nxt        = ~r_last_grant;
          w_last_grant_nxt = ~r_last_grant;
          w_state_nxt      = BYTE0;
        end else if (req0_valid) begin
          w_gnt_nxt        = 1'b0;
          w_last_grant_nxt = 1'b0;
          w_state_nxt      = BYTE0;
        end else if (req1_valid) begin
          w_gnt_nxt        = 1'b1;
          w_last_grant_nxt = 1'b1;
          w_state_nxt      = BYTE0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BYTE0: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else begin
          w_ready0 = ~r_gnt;
          w_ready1 = r_gnt;
          if (w_sel_valid) begin
            w_take_byte0 = 1'b1;
            w_state_nxt  = BYTE1;
          end else begin
            w_state_nxt = BYTE0;
          end
        end
      end
      BYTE1: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else begin
          w_ready0 = ~r_gnt;
          w_ready1 = r_gnt;
          if (w_sel_valid) begin
            w_take_byte1 = 1'b1;
            w_state_nxt  = HOLD;
          end else begin
            w_state_nxt = BYTE1;
          end
        end
      end
      HOLD: begin
        // flush is deliberately ignored here: a completed word is committed
        if (out_ready) begin
          w_out_hs    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Packed word, source tag, output valid and handshake counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 1'b0;
      r_out_cnt   <= 8'd0;
    end else begin
      if (w_take_byte0) begin
        r_out_data[2*DW-1:DW] <= w_sel_data;
      end
      if (w_take_byte1) begin
        r_out_data[DW-1:0] <= w_sel_data;
        r_out_src          <= r_gnt;
        r_out_valid        <= 1'b1;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_out_cnt   <= r_out_cnt + 8'd1;
      end
    end
  end

  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_src    = r_out_src;
  assign out_cnt    = r_out_cnt;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_byte_pair_arbiter.sv
// Directed self-checking bench for byte_pair_arbiter.
// Inputs change on the falling edge; outputs are sampled there too, half a cycle from the active edge.
module tb_byte_pair_arbiter;

  localparam int DW = 8;

  logic            clk;
  logic            rst;
  logic            req0_valid;
  logic [DW-1:0]   req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [DW-1:0]   req1_data;
  logic            req1_ready;
  logic            flush;
  logic            out_valid;
  logic [2*DW-1:0] out_data;
  logic            out_src;
  logic            out_ready;
  logic            busy;
  logic [7:0]      out_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  byte_pair_arbiter #(.DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .busy       (busy),
    .out_cnt    (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req0_valid = 1'b0;
    req0_data  = 8'h00;
    req1_valid = 1'b0;
    req1_data  = 8'h00;
    flush      = 1'b0;
    out_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer b0 then b1 from one requester; returns at the falling edge where the word sits in HOLD.
  task automatic send_word(input logic src, input logic [7:0] b0, input logic [7:0] b1);
    int   taken;
    int   guard;
    logic w;
    taken = 0;
    guard = 0;
    if (src) begin req1_valid = 1'b1; req1_data = b0; end
    else     begin req0_valid = 1'b1; req0_data = b0; end
    while (taken < 2 && guard < 20) begin
      #1;
      w = src ? req1_ready : req0_ready;
      @(negedge clk);
      if (w) begin
        taken++;
        if (src) req1_data = b1; else req0_data = b1;
        if (taken == 2) begin
          if (src) req1_valid = 1'b0; else req0_valid = 1'b0;
        end
      end
      guard++;
    end
    if (taken < 2) chk("send_word_timeout", 32'(taken), 32'd2);
  endtask

  logic [7:0]  q0 [4];
  logic [7:0]  q1 [4];
  logic [15:0] exp_w [4];
  logic        exp_s [4];
  logic [15:0] got_w [4];
  logic        got_s [4];

  initial begin
    int   cyc;
    int   nw;
    int   i0;
    int   i1;
    logic p0;
    logic p1;
    logic seen_r1;
    logic [7:0] cnt_before;

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0000);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    chk("rst_readies", 32'({req0_ready, req1_ready}), 32'd0);

    // ---------------- single requester ----------------
    out_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 8'hA5;
    cyc     = 0;
    i0      = 0;
    seen_r1 = 1'b0;
    while (!out_valid && cyc < 20) begin
      #1;
      p0 = req0_ready;
      seen_r1 = seen_r1 | req1_ready;
      @(negedge clk);
      cyc++;
      if (p0) begin
        i0++;
        req0_data = 8'h3C;
        if (i0 == 2) req0_valid = 1'b0;
      end
    end
    chk("single_latency", 32'(cyc), 32'd3);
    chk("single_data", 32'(out_data), 32'hA53C);
    chk("single_src", 32'(out_src), 32'd0);
    chk("single_ready_hold", 32'({req0_ready, req1_ready}), 32'd0);
    @(negedge clk);
    chk("single_cnt", 32'(out_cnt), 32'd1);
    chk("single_valid_drop", 32'(out_valid), 32'd0);
    chk("single_r1_never", 32'(seen_r1), 32'd0);

    // ---------------- tie and alternation ----------------
    do_reset();
    q0    = '{8'h11, 8'h22, 8'h33, 8'h44};
    q1    = '{8'h55, 8'h66, 8'h77, 8'h88};
    exp_w = '{16'h1122, 16'h5566, 16'h3344, 16'h7788};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
    out_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_data  = q0[0];
    req1_valid = 1'b1;
    req1_data  = q1[0];
    i0 = 0;
    i1 = 0;
    nw = 0;
    cyc = 0;
    while (nw < 4 && cyc < 60) begin
      #1;
      p0 = req0_ready & req0_valid;
      p1 = req1_ready & req1_valid;
      if (out_valid) begin
        got_w[nw] = out_data;
        got_s[nw] = out_src;
        nw++;
      end
      @(negedge clk);
      cyc++;
      if (p0) begin
        i0++;
        if (i0 < 4) req0_data = q0[i0]; else req0_valid = 1'b0;
      end
      if (p1) begin
        i1++;
        if (i1 < 4) req1_data = q1[i1]; else req1_valid = 1'b0;
      end
    end
    chk("tie_word_count", 32'(nw), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < nw) begin
        chk($sformatf("tie_data%0d", k), 32'(got_w[k]), 32'(exp_w[k]));
        chk($sformatf("tie_src%0d", k), 32'(got_s[k]), 32'(exp_s[k]));
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    // ---------------- back-pressure ----------------
    do_reset();
    out_ready = 1'b0;
    send_word(1'b1, 8'hC3, 8'h5A);
    cnt_before = out_cnt;
    req0_valid = 1'b1;
    req0_data  = 8'hEE;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_data%0d", k), 32'(out_data), 32'hC35A);
      chk($sformatf("bp_src%0d", k), 32'(out_src), 32'd1);
      chk($sformatf("bp_ready%0d", k), 32'({req0_ready, req1_ready}), 32'd0);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    chk("bp_cnt_held", 32'(out_cnt), 32'(cnt_before));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_cnt_release", 32'(out_cnt), 32'(cnt_before + 8'd1));
    chk("bp_valid_release", 32'(out_valid), 32'd0);

    // ---------------- flush ----------------
    do_reset();
    out_ready  = 1'b1;
    req1_valid = 1'b1;
    req1_data  = 8'h9A;
    @(negedge clk);
    #1;
    chk("fl_byte0_ready1", 32'(req1_ready), 32'd1);
    @(negedge clk);
    req1_data = 8'hBC;
    flush     = 1'b1;
    #1;
    chk("fl_busy_byte1", 32'(busy), 32'd1);
    chk("fl_ready_forced", 32'({req0_ready, req1_ready}), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_idle", 32'(busy), 32'd0);
    chk("fl_no_word", 32'(out_valid), 32'd0);
    req0_valid = 1'b1;
    req0_data  = 8'h01;
    @(negedge clk);
    #1;
    chk("fl_next_grant", 32'({req0_ready, req1_ready}), 32'b10);
    @(negedge clk);
    req0_data = 8'h02;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("fl_word_data", 32'(out_data), 32'h0102);
    chk("fl_word_src", 32'(out_src), 32'd0);
    chk("fl_cnt_before", 32'(out_cnt), 32'd0);
    @(negedge clk);
    chk("fl_cnt_after", 32'(out_cnt), 32'd1);

    // ---------------- async reset mid-word ----------------
    do_reset();
    out_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 8'h77;
    @(negedge clk);
    @(negedge clk);
    req0_data = 8'h78;
    chk("ar_busy_byte1", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy_drop", 32'(busy), 32'd0);
    chk("ar_valid_drop", 32'(out_valid), 32'd0);
    chk("ar_ready_drop", 32'({req0_ready, req1_ready}), 32'd0);
    chk("ar_data_drop", 32'(out_data), 32'h0000);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("ar_first_tie", 32'({req0_ready, req1_ready}), 32'b10);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // ---------------- counter wrap ----------------
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      send_word(1'b0, 8'(k), 8'(~k));
      if (k == 255) begin
        chk("wrap_last_data", 32'(out_data), 32'hFF00);
        chk("wrap_cnt_255", 32'(out_cnt), 32'd255);
      end
      @(negedge clk);
    end
    chk("wrap_cnt_zero", 32'(out_cnt), 32'd0);
    chk("wrap_valid", 32'(out_valid), 32'd0);
    chk("wrap_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/byte_pair_arbiter.md
# byte_pair_arbiter

Arbitrates between two byte-stream requesters for one shared byte-pair packer and emits packed 16-bit words tagged with their source. Each grant is word-atomic: the granted requester keeps the packer until two bytes have been taken. The packed word is then held in a one-entry output register until the downstream consumer accepts it. The block sits in front of the decimation datapath and sequences all writes into it.

## Interface
- DW, 8, byte width; output word is 2*DW bits
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a byte
- req0_data  in  DW  requester 0 byte
- req0_ready  out  1  byte from requester 0 accepted this cycle when high with req0_valid
- req1_valid / req1_data / req1_ready  same as requester 0, for requester 1
- flush  in  1  synchronous; abandons a partially packed word
- out_valid  out  1  packed word available
- out_data  out  2*DW  packed word: first byte in [2*DW-1:DW], second byte in [DW-1:0]
- out_src  out  1  requester that supplied out_data
- out_ready  in  1  consumer accepts the word when high with out_valid
- busy  out  1  high whenever state != IDLE
- out_cnt  out  8  completed output handshakes, wraps 255 -> 0

## Operation
- Reset values: state IDLE, last_grant=1 (requester 0 wins the first tie), gnt=0, out_valid=0, out_data=0, out_src=0, out_cnt=0, both ready outputs 0, busy=0.
- States: IDLE, BYTE0, BYTE1, HOLD.
- **IDLE**
  - If only one reqN_valid is high, grant N.
  - If both are high, grant !last_grant.
  - On a grant: gnt<=N, last_grant<=N, state -> BYTE0.
  - No byte is accepted in IDLE. Both ready outputs are 0.
- **BYTE0**
  - reqN_ready = (gnt==N) & !flush. This is combinational and held low for the non-granted requester.
  - On handshake: out_data[2*DW-1:DW]<=data, state -> BYTE1.
  - If the granted requester's valid is low, wait. The grant is never revoked except by flush.
- **BYTE1**
  - Same ready rule as BYTE0.
  - On handshake: out_data[DW-1:0]<=data, out_src<=gnt, out_valid<=1, state -> HOLD.
- **HOLD**
  - out_valid=1. Both ready outputs are 0.
  - out_data and out_src are stable until the handshake.
  - On out_valid & out_ready: out_valid<=0, out_cnt<=out_cnt+1, state -> IDLE.
- **flush**
  - In BYTE0 or BYTE1: state -> IDLE next cycle. Any partial byte is discarded, no word is emitted, and last_grant keeps the value set at grant time.
  - flush forces ready low in the same cycle, so no byte is consumed in that cycle.
  - In IDLE or HOLD, flush has no effect. A word in HOLD is committed.
- Round-robin fairness: with both requesters continuously valid, grants alternate 0,1,0,1,...
- Data bytes are never reordered within a requester.
- Out-of-range state encodings recover to IDLE.

## Timing
- Request at IDLE edge n:
  - grant registered at n+1 (BYTE0)
  - byte0 accepted at n+1 if valid
  - byte1 accepted at n+2
  - out_valid high from n+3
- Minimum 4 cycles per word with out_ready tied high (IDLE, BYTE0, BYTE1, HOLD). No back-to-back bypass.
- Back-pressure: out_ready low holds HOLD indefinitely. Requesters see ready=0 throughout.
- Reset is asynchronous and takes effect immediately, including mid-word. A partial word is lost. Outputs go to their reset values without waiting for clk.
- Ready signals are combinational from state, gnt and flush only. There is no combinational path from valid to ready.

## Test plan
- **Single requester.** After reset, req0 presents 0xA5 then 0x3C, out_ready=1. Required: out_valid at cycle 3 after first valid, out_data=0xA53C, out_src=0, out_cnt=1, req1_ready never high.
- **Tie and alternation.** req0 streams 0x11,0x22,0x33,0x44 and req1 streams 0x55,0x66,0x77,0x88, both always valid. Required word order: 0x1122(src0), 0x5566(src1), 0x3344(src0), 0x7788(src1).
- **Back-pressure.** out_ready low for 10 cycles in HOLD. Required: out_valid stays 1, out_data and out_src unchanged, both ready outputs 0, out_cnt increments by exactly 1 on release.
- **Flush.** req1 granted, byte 0x9A accepted, flush pulsed in BYTE1 while req1_valid=1. Required: req1_ready=0 that cycle, no word emitted, next grant goes to req0 if both are valid.
- **Async reset mid-word.** rst asserted between clock edges while in BYTE1. Required: busy, out_valid and ready outputs drop immediately. After release, the first tie grants req0.
- **Counter wrap.** Complete 256 words. Required: out_cnt returns to 0, with no other side effects.
